// File: rtl/pool_fc_stage.sv
// pool_fc_stage: 2x2 max/average pooling into a channel-major buffer,
// followed by a K-class multiply-accumulate against streamed weights.
module pool_fc_stage #(
   parameter int CH = 8,
   parameter int PX = 12,
   parameter int PY = 12,
   parameter int DW = 69,
   parameter int WW = 32,
   parameter int K  = 10,
   parameter int AW = 113
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pool_mode,
   input  logic                         flush,
   input  logic                         win_valid,
   output logic                         win_ready,
   input  logic [CH*4*DW-1:0]           win_data,
   output logic                         w_rd_en,
   output logic [$clog2(CH*PX*PY)-1:0]  w_addr,
   input  logic [K*WW-1:0]              w_data,
   output logic [K*AW-1:0]              prob,
   output logic                         prob_valid,
   input  logic                         prob_ready
);

   localparam int NW = PX * PY;
   localparam int N  = CH * NW;
   localparam int NA = $clog2(N);
   localparam int WA = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_MAC,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 w_beat;
   logic                 w_mode;
   logic                 w_last_beat;
   logic [WA-1:0]        r_wi;
   logic [WA-1:0]        w_wi;
   logic                 r_mode;
   logic signed [DW-1:0] r_buf [N];
   logic signed [DW-1:0] w_pool [CH];
   logic                 r_rd_en;
   logic                 r_vld;
   logic                 r_last;
   logic [NA-1:0]        r_addr;
   logic signed [DW-1:0] r_bdat;
   logic signed [AW-1:0] r_acc [K];
   logic signed [AW-1:0] w_prod [K];

   // Average uses a DW+2 bit sum so the floor shift never overflows.
   function automatic logic signed [DW-1:0] f_pool(
      input logic [4*DW-1:0] win,
      input logic            avg
   );
      logic signed [DW-1:0] e [4];
      logic signed [DW-1:0] m;
      logic signed [DW+1:0] s;
      for (int i = 0; i < 4; i++) begin
         e[i] = win[i*DW +: DW];
      end
      m = e[0];
      s = '0;
      for (int i = 1; i < 4; i++) begin
         if (e[i] > m) m = e[i];
      end
      for (int i = 0; i < 4; i++) begin
         s = s + {{2{e[i][DW-1]}}, e[i]};
      end
      return avg ? DW'(s >>> 2) : m;
   endfunction

   assign win_ready   = (r_state == S_IDLE || r_state == S_FILL) && !flush;
   assign w_beat      = win_valid && win_ready;
   assign w_mode      = (r_state == S_IDLE) ? pool_mode : r_mode;
   assign w_wi        = (r_state == S_IDLE) ? '0 : r_wi;
   assign w_last_beat = (w_wi == WA'(NW - 1));
   assign prob_valid  = (r_state == S_DONE) && !flush;
   assign w_rd_en     = r_rd_en;
   assign w_addr      = r_addr;

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         w_pool[c] = f_pool(win_data[4*c*DW +: 4*DW], w_mode);
      end
   end

   always_comb begin
      prob = '0;
      for (int k = 0; k < K; k++) begin
         w_prod[k] = $signed({{(AW-DW){r_bdat[DW-1]}}, r_bdat})
                   * $signed({{(AW-WW){w_data[k*WW+WW-1]}},
                              w_data[k*WW +: WW]});
         prob[k*AW +: AW] = r_acc[k];
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_FILL: begin
            if (w_beat && w_last_beat) w_next = S_MAC;
            else if (w_beat)           w_next = S_FILL;
         end
         S_MAC: begin
            if (r_vld && r_last) w_next = S_DONE;
         end
         S_DONE: begin
            if (prob_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode  <= 1'b0;
         r_wi    <= '0;
         r_rd_en <= 1'b0;
         r_addr  <= '0;
         r_vld   <= 1'b0;
         r_last  <= 1'b0;
         for (int k = 0; k < K; k++) r_acc[k] <= '0;
      end else if (flush) begin
         r_rd_en <= 1'b0;
         r_addr  <= '0;
         r_vld   <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_vld  <= r_rd_en;
         r_last <= r_rd_en && (r_addr == NA'(N - 1));
         if (r_rd_en) begin
            if (r_addr == NA'(N - 1)) r_rd_en <= 1'b0;
            else                      r_addr  <= r_addr + 1'b1;
         end
         if (w_beat) begin
            r_wi <= w_wi + 1'b1;
            if (r_state == S_IDLE) begin
               r_mode <= pool_mode;
               for (int k = 0; k < K; k++) r_acc[k] <= '0;
            end
            if (w_last_beat) begin
               r_rd_en <= 1'b1;
               r_addr  <= '0;
            end
         end
         if (r_vld) begin
            for (int k = 0; k < K; k++) r_acc[k] <= r_acc[k] + w_prod[k];
         end
      end
   end

   // Storage only; contents after reset are never observed.
   always_ff @(posedge clk) begin
      if (w_beat) begin
         for (int c = 0; c < CH; c++) begin
            r_buf[NA'(c*NW) + NA'(w_wi)] <= w_pool[c];
         end
      end
      if (r_rd_en) r_bdat <= r_buf[r_addr];
   end

endmodule

// File: tb/tb_pool_fc_stage.sv
// Scoreboard bench for pool_fc_stage: a reference model pushes expected
// scores per frame, popped and compared on each prob handshake.
module tb_pool_fc_stage;

   localparam int CH = 2;
   localparam int PX = 2;
   localparam int PY = 2;
   localparam int DW = 16;
   localparam int WW = 8;
   localparam int K  = 2;
   localparam int AW = 40;
   localparam int N  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              pool_mode;
   logic              flush;
   logic              win_valid;
   logic              win_ready;
   logic [CH*4*DW-1:0] win_data;
   logic              w_rd_en;
   logic [2:0]        w_addr;
   logic [K*WW-1:0]   w_data = '0;
   logic [K*AW-1:0]   prob;
   logic              prob_valid;
   logic              prob_ready;

   pool_fc_stage #(
      .CH(CH), .PX(PX), .PY(PY), .DW(DW), .WW(WW), .K(K), .AW(AW)
   ) dut (
      .clk(clk), .rst(rst), .pool_mode(pool_mode), .flush(flush),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
      .prob(prob), .prob_valid(prob_valid), .prob_ready(prob_ready)
   );

   always #5 clk = ~clk;

   logic signed [WW-1:0] wt0 [N];
   logic signed [WW-1:0] wt1 [N];

   always @(posedge clk) begin
      if (w_rd_en) w_data <= {wt1[w_addr], wt0[w_addr]};
   end

   int     n_vec = 0;
   int     n_bad = 0;
   int     cyc = 0;
   int     last_edge = 0;
   int     rise_cyc = 0;
   bit     pv_d = 1'b0;
   bit     pv_seen = 1'b0;
   longint q0[$];
   longint q1[$];
   longint last_p0 = 0;
   longint last_p1 = 0;
   int     addr_q[$];
   logic [CH*4*DW-1:0] frm [4];

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sx(input logic [AW-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [4*DW-1:0] mkch(input int a, input int b,
                                            input int c, input int d);
      return {DW'(d), DW'(c), DW'(b), DW'(a)};
   endfunction

   function automatic int rv();
      return int'($urandom_range(0, 400)) - 200;
   endfunction

   function automatic void model(input bit mode, output longint s0,
                                 output longint s1);
      s0 = 0;
      s1 = 0;
      for (int b = 0; b < 4; b++) begin
         for (int c = 0; c < CH; c++) begin
            int e [4];
            int p;
            logic [DW-1:0] t;
            for (int i = 0; i < 4; i++) begin
               t = frm[b][(4*c+i)*DW +: DW];
               e[i] = int'($signed(t));
            end
            if (mode) begin
               p = (e[0] + e[1] + e[2] + e[3]) >>> 2;
            end else begin
               p = e[0];
               for (int i = 1; i < 4; i++) if (e[i] > p) p = e[i];
            end
            s0 += longint'(p) * longint'(wt0[c*4+b]);
            s1 += longint'(p) * longint'(wt1[c*4+b]);
         end
      end
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         if (prob_valid && !pv_d) rise_cyc = cyc;
         if (prob_valid) pv_seen = 1'b1;
         if (w_rd_en) addr_q.push_back(int'(w_addr));
         if (prob_valid && prob_ready) begin
            last_p0 = sx(prob[AW-1:0]);
            last_p1 = sx(prob[2*AW-1:AW]);
            if (q0.size() == 0) begin
               chk("sb_depth", q0.size(), 1);
            end else begin
               chk("prob0", last_p0, q0.pop_front());
               chk("prob1", last_p1, q1.pop_front());
            end
         end
      end
      pv_d = prob_valid;
   end

   task automatic rnd_frame();
      for (int b = 0; b < 4; b++) begin
         frm[b] = {mkch(rv(), rv(), rv(), rv()), mkch(rv(), rv(), rv(), rv())};
      end
   endtask

   task automatic rnd_wts();
      for (int i = 0; i < N; i++) begin
         wt0[i] = WW'(int'($urandom_range(0, 60)) - 30);
         wt1[i] = WW'(int'($urandom_range(0, 60)) - 30);
      end
   endtask

   task automatic send(input bit mode, input int nb, input int gap);
      for (int b = 0; b < nb; b++) begin
         int t = 0;
         win_data  = frm[b];
         pool_mode = mode;
         win_valid = 1'b1;
         @(negedge clk);
         while (!win_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("beat_accept", int'(win_ready), 1);
         @(posedge clk);
         #1;
         last_edge = cyc;
         win_valid = 1'b0;
         pool_mode = 1'($urandom);
         win_data  = {$urandom, $urandom, $urandom, $urandom};
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain();
      int t = 0;
      while (q0.size() != 0 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain", q0.size(), 0);
   endtask

   task automatic frame(input bit mode, input int gap);
      longint e0, e1;
      model(mode, e0, e1);
      q0.push_back(e0);
      q1.push_back(e1);
      send(mode, 4, gap);
      drain();
   endtask

   task automatic wait_pv();
      int t = 0;
      while (!prob_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("pv_wait", int'(prob_valid), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      longint e0, e1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         wt0[i] = '0;
         wt1[i] = '0;
      end
      repeat (4) begin
         pool_mode  = 1'($urandom);
         flush      = 1'($urandom);
         win_valid  = 1'($urandom);
         prob_ready = 1'($urandom);
         win_data   = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk);
         #1;
      end
      chk("rst_pv_lo", int'(prob_valid), 0);
      chk("rst_rd_lo", int'(w_rd_en), 0);
      flush = 1'b0; win_valid = 1'b0; prob_ready = 1'b1; pool_mode = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_prob0", sx(prob[AW-1:0]), 0);
      chk("rst_prob1", sx(prob[2*AW-1:AW]), 0);
      chk("rst_pv", int'(prob_valid), 0);
      chk("rst_rd", int'(w_rd_en), 0);
      chk("rst_addr", int'(w_addr), 0);
      chk("rst_ready", int'(win_ready), 1);
      @(posedge clk);
      #1;

      // max mode, negative data
      for (int b = 0; b < 4; b++) begin
         frm[b] = {mkch(-5, -3, -9, -4), mkch(-5, -3, -9, -4)};
      end
      for (int i = 0; i < N; i++) begin
         wt0[i] = 8'sd1;
         wt1[i] = -8'sd2;
      end
      addr_q.delete();
      frame(1'b0, 0);
      chk("latency", rise_cyc - last_edge, 9);
      chk("max_p0", last_p0, -24);
      chk("max_p1", last_p1, 48);
      chk("addr_cnt", addr_q.size(), 8);
      for (int i = 0; i < addr_q.size() && i < 8; i++) begin
         chk("addr_seq", addr_q[i], i);
      end

      // average mode floor
      for (int b = 0; b < 4; b++) begin
         frm[b] = {mkch(-1, 0, 0, 0), mkch(7, 0, 0, 0)};
      end
      for (int i = 0; i < N; i++) begin
         wt0[i] = 8'sd1;
         wt1[i] = 8'sd0;
      end
      frame(1'b1, 0);
      chk("avg_p0", last_p0, 0);
      chk("avg_p1", last_p1, 0);
      for (int i = 0; i < N; i++) begin
         wt0[i] = (i < 4) ? 8'sd1 : 8'sd0;
         wt1[i] = (i < 4) ? 8'sd0 : 8'sd1;
      end
      frame(1'b1, 0);
      chk("avg_ch0", last_p0, 4);
      chk("avg_ch1", last_p1, -4);

      // backpressure
      rnd_frame();
      rnd_wts();
      frame(1'b1, 0);
      prob_ready = 1'b0;
      model(1'b1, e0, e1);
      q0.push_back(e0);
      q1.push_back(e1);
      send(1'b1, 4, 1);
      wait_pv();
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold0", sx(prob[AW-1:0]), e0);
         chk("bp_hold1", sx(prob[2*AW-1:AW]), e1);
         chk("bp_ready", int'(win_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      prob_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_pv", int'(prob_valid), 0);
      chk("hs_ready", int'(win_ready), 1);
      chk("bp_drain", q0.size(), 0);

      // flush on MAC cycle 3, then a fresh frame
      rnd_frame();
      rnd_wts();
      pv_seen = 1'b0;
      send(1'b0, 4, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      chk("abort_pv", int'(pv_seen), 0);
      chk("abort_rd", int'(w_rd_en), 0);
      rnd_frame();
      frame(1'b0, 0);

      // flush coinciding with a beat
      win_data = frm[0];
      win_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_ready", int'(win_ready), 0);
      @(posedge clk);
      #1;
      win_valid = 1'b0;
      flush = 1'b0;
      rnd_frame();
      frame(1'b1, 0);

      // async reset mid-FILL, then a full frame
      rnd_frame();
      send(1'b0, 2, 0);
      #3 rst = 1'b0;
      #1;
      chk("arst_pv", int'(prob_valid), 0);
      chk("arst_rd", int'(w_rd_en), 0);
      chk("arst_prob0", sx(prob[AW-1:0]), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rnd_frame();
      frame(1'b0, 0);

      // async reset while scores are held
      rnd_frame();
      rnd_wts();
      prob_ready = 1'b0;
      model(1'b1, e0, e1);
      send(1'b1, 4, 0);
      wait_pv();
      chk("done_p0", sx(prob[AW-1:0]), e0);
      #2 rst = 1'b0;
      #1;
      chk("arst2_pv", int'(prob_valid), 0);
      chk("arst2_p0", sx(prob[AW-1:0]), 0);
      chk("arst2_p1", sx(prob[2*AW-1:AW]), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      prob_ready = 1'b1;
      @(posedge clk);
      #1;
      rnd_frame();
      frame(1'b1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
